logic_unit_pipe: RTL and testbench

//   Parametrised, registered successor to the 8-bit combinational logic unit.

---
 rtl/logic_unit_pipe_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 116 +++++++++++
 tb/tb_logic_unit_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Master drives operands and consumer ready; slave is the logic unit.
interface logic_unit_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       s;
   logic             acc_sel;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] logic_out;
   logic             zero;
   logic             parity;

   modport master (
      output in_valid, A, B, s, acc_sel, acc_clr, out_ready,
      input  in_ready, out_valid, logic_out, zero, parity
   );

   modport slave (
      input  in_valid, A, B, s, acc_sel, acc_clr, out_ready,
      output in_ready, out_valid, logic_out, zero, parity
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit: eight bitwise ops, accumulator operand,
// zero/parity flags, and a 2-entry valid/ready output buffer.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   logic_unit_pipe_if.slave   bus
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             parity;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fill_e;

   fill_e            fill_q, fill_d;
   entry_t           head_q, head_d;
   entry_t           tail_q, tail_d;
   entry_t           new_ent;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] res;
   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             pop;

   // in_ready depends on registered fill state only, never on out_ready.
   always_comb begin
      in_ready  = (fill_q != FULL);
      out_valid = (fill_q != EMPTY);
      accept    = bus.in_valid & in_ready;
      pop       = out_valid & bus.out_ready;
   end

   always_comb begin
      a_eff = bus.acc_sel ? (bus.acc_clr ? '0 : acc_q) : bus.A;
      unique case (bus.s)
         3'b000:  res = a_eff & bus.B;
         3'b001:  res = a_eff ^ bus.B;
         3'b010:  res = a_eff | bus.B;
         3'b011:  res = ~bus.B;
         3'b100:  res = ~(a_eff & bus.B);
         3'b101:  res = ~(a_eff ^ bus.B);
         3'b110:  res = ~(a_eff | bus.B);
         default: res = ~a_eff;
      endcase
      new_ent.data   = res;
      new_ent.zero   = (res == '0);
      new_ent.parity = ^res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= EMPTY;
         head_q <= '0;
         tail_q <= '0;
         acc_q  <= '0;
      end else begin
         fill_q <= fill_d;
         head_q <= head_d;
         tail_q <= tail_d;
         acc_q  <= acc_d;
      end
   end

   always_comb begin
      fill_d = fill_q;
      unique case (fill_q)
         EMPTY: if (accept) fill_d = ONE;
         ONE: begin
            if (accept && !pop)      fill_d = FULL;
            else if (!accept && pop) fill_d = EMPTY;
         end
         FULL:    if (pop) fill_d = ONE;
         default: fill_d = EMPTY;
      endcase
   end

   // Head is always the oldest entry; tail only holds the second of two.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      unique case (fill_q)
         EMPTY: if (accept) head_d = new_ent;
         ONE: begin
            if (accept && pop) head_d = new_ent;
            else if (accept)   tail_d = new_ent;
         end
         FULL:    if (pop) head_d = tail_q;
         default: ;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (accept)           acc_d = res;
      else if (bus.acc_clr) acc_d = '0;
   end

   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = out_valid;
      bus.logic_out = out_valid ? head_q.data   : '0;
      bus.zero      = out_valid ? head_q.zero   : 1'b0;
      bus.parity    = out_valid ? head_q.parity : 1'b0;
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: constant vector table, scoreboard
// of accepted bundles, and hand-written backpressure/throughput/reset sequences.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned cyc = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic_unit_pipe_if #(.WIDTH(8))  bus8 ();
   logic_unit_pipe_if #(.WIDTH(16)) bus16 ();

   logic_unit_pipe #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   logic_unit_pipe #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] s;
      logic       sel;
      logic       pre_clr;
      logic [7:0] d;
      logic       z;
      logic       p;
   } vec_t;

   logic [9:0] sb_q[$];
   int unsigned pop_cyc_q[$];
   logic [7:0] acc_m = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      case (s)
         3'd0:    return a & b;
         3'd1:    return a ^ b;
         3'd2:    return a | b;
         3'd3:    return ~b;
         3'd4:    return ~(a & b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~(a | b);
         default: return ~a;
      endcase
   endfunction

   // Result monitor: every pop is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus8.out_valid && bus8.out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h expected no result",
                     {bus8.logic_out, bus8.zero, bus8.parity});
         end else begin
            chk("sb_result", 32'({bus8.logic_out, bus8.zero, bus8.parity}), 32'(sb_q.pop_front()));
         end
         pop_cyc_q.push_back(cyc);
      end
   end

   // Drive one bundle, wait (bounded) for acceptance, push its expectation.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                       input logic sel, input logic clr, input logic use_tab,
                       input logic [9:0] tab, output int unsigned acc_at, output int stalls);
      logic [7:0] ea;
      logic [7:0] r;
      logic [9:0] e;
      stalls = 0;
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.A        = a;
      bus8.B        = b;
      bus8.s        = s;
      bus8.acc_sel  = sel;
      bus8.acc_clr  = clr;
      while (!bus8.in_ready && stalls < 50) begin
         @(negedge clk);
         stalls++;
      end
      acc_at = cyc;
      if (!bus8.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
         bus8.in_valid = 1'b0;
         return;
      end
      ea = sel ? (clr ? 8'h00 : acc_m) : a;
      r  = op8(ea, b, s);
      e  = use_tab ? tab : {r, (r == 8'h00), ^r};
      sb_q.push_back(e);
      acc_m = e[9:2];
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      bus8.acc_clr  = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.acc_clr  = 1'b1;
      @(posedge clk);
      #1;
      bus8.acc_clr = 1'b0;
      acc_m = 8'h00;
   endtask

   task automatic drain();
      int b = 0;
      while (sb_q.size() != 0 && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      end
      @(negedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1;
      bus8.out_ready = v;
   endtask

   vec_t vecs[14];

   initial begin
      int unsigned at;
      int unsigned first_acc;
      int st;
      int st_total;

      vecs[0]  = '{8'hF0, 8'h1C, 3'd0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
      vecs[1]  = '{8'hF0, 8'h1C, 3'd1, 1'b0, 1'b0, 8'hEC, 1'b0, 1'b1};
      vecs[2]  = '{8'hF0, 8'h1C, 3'd2, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0};
      vecs[3]  = '{8'hF0, 8'h1C, 3'd3, 1'b0, 1'b0, 8'hE3, 1'b0, 1'b1};
      vecs[4]  = '{8'hF0, 8'h1C, 3'd4, 1'b0, 1'b0, 8'hEF, 1'b0, 1'b1};
      vecs[5]  = '{8'hF0, 8'h1C, 3'd5, 1'b0, 1'b0, 8'h13, 1'b0, 1'b1};
      vecs[6]  = '{8'hF0, 8'h1C, 3'd6, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[7]  = '{8'hF0, 8'h1C, 3'd7, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
      vecs[8]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[10] = '{8'hAA, 8'h01, 3'd2, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
      vecs[11] = '{8'hAA, 8'h02, 3'd2, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[12] = '{8'hAA, 8'h04, 3'd2, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
      vecs[13] = '{8'hAA, 8'h00, 3'd7, 1'b1, 1'b0, 8'hF8, 1'b0, 1'b1};

      bus8.in_valid  = 1'b0;
      bus8.A         = '0;
      bus8.B         = '0;
      bus8.s         = '0;
      bus8.acc_sel   = 1'b0;
      bus8.acc_clr   = 1'b0;
      bus8.out_ready = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.A         = '0;
      bus16.B         = '0;
      bus16.s         = '0;
      bus16.acc_sel   = 1'b0;
      bus16.acc_clr   = 1'b0;
      bus16.out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst_logic_out", 32'(bus8.logic_out), 32'd0);
      chk("rst_zero",      32'(bus8.zero),      32'd0);
      chk("rst_parity",    32'(bus8.parity),    32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);

      // Table: op coverage, zero/parity corners, accumulator chain
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].pre_clr) clr_pulse();
         send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sel, 1'b0, 1'b1,
              {vecs[i].d, vecs[i].z, vecs[i].p}, at, st);
      end
      drain();

      // Backpressure: two buffered, third held until the consumer drains
      set_ready(1'b0);
      send(8'h3C, 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 10'd0, at, st);
      @(negedge clk);
      chk("bp_ready_after_1", 32'(bus8.in_ready), 32'd1);
      send(8'h3C, 8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0, at, st);
      @(negedge clk);
      chk("bp_ready_after_2", 32'(bus8.in_ready), 32'd0);
      chk("bp_valid_full",    32'(bus8.out_valid), 32'd1);
      chk("bp_head_first",    32'(bus8.logic_out), 32'h66);
      bus8.in_valid = 1'b1;
      bus8.A = 8'h3C;
      bus8.B = 8'h5A;
      bus8.s = 3'd2;
      repeat (2) @(negedge clk);
      chk("bp_third_held", 32'(bus8.in_ready), 32'd0);
      set_ready(1'b1);
      send(8'h3C, 8'h5A, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0, at, st);
      drain();

      // Throughput: eight back-to-back bundles with consumer always ready
      pop_cyc_q.delete();
      st_total = 0;
      first_acc = 0;
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 10'd0, at, st);
         if (i == 0) first_acc = at;
         st_total += st;
      end
      drain();
      chk("tput_no_stall",  32'(st_total), 32'd0);
      chk("tput_count",     32'(pop_cyc_q.size()), 32'd8);
      chk("tput_latency",   32'(pop_cyc_q[0] - first_acc), 32'd1);
      chk("tput_span",      32'(pop_cyc_q[7] - pop_cyc_q[0]), 32'd7);

      // 16-bit instance
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.A = 16'h1234;
      bus16.B = 16'h00FF;
      bus16.s = 3'd3;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      @(negedge clk);
      chk("w16_valid", 32'(bus16.out_valid), 32'd1);
      chk("w16_out",   32'(bus16.logic_out), 32'hFF00);
      chk("w16_flags", 32'({bus16.zero, bus16.parity}), 32'd0);

      // Asynchronous reset with two buffered results and a non-zero accumulator
      set_ready(1'b0);
      send(8'h81, 8'h42, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0, at, st);
      send(8'h81, 8'h42, 3'd1, 1'b0, 1'b0, 1'b0, 10'd0, at, st);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("arst_logic_out", 32'(bus8.logic_out), 32'd0);
      sb_q.delete();
      acc_m = 8'h00;
      @(posedge clk);
      #2 rst_n = 1'b1;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      chk("arst_in_ready", 32'(bus8.in_ready), 32'd1);
      send(8'hFF, 8'h05, 3'd2, 1'b1, 1'b0, 1'b1, {8'h05, 1'b0, 1'b0}, at, st);
      drain();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
